cvxif_offload_master: RTL and testbench
=======================================

CVXIF_OFFLOAD_MASTER -- requirements
Module: cvxif_offload_master

Interface
REQ-001 Parameter: TIMEOUT, default 1023, max cycles waited in RESP for result_valid before abort.
REQ-002 Parameter: CNT_W, default 10, timeout counter width; SHALL satisfy 2**CNT_W > TIMEOUT.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  core offers instruction plus operands.
REQ-006 cmd_ready  out  1  block can take a command (IDLE only).
REQ-007 cmd_instr  in  32  instruction word.
REQ-008 cmd_rs0, cmd_rs1  in  32 each  source operand values.
REQ-009 wb_valid  out  1  completion available to core.
REQ-010 wb_ready  in  1  core takes completion.
REQ-011 wb_data  out  32  result value, 0 on error.
REQ-012 wb_err  out  1  1 = rejected or timed out.
REQ-013 issue_valid  out  1; issue_ready  in  1; issue_req_instr  out  32; issue_resp_accept  in  1; issue_resp_writeback  in  1; issue_resp_register_read  in  2 -- coprocessor issue channel.
REQ-014 register_valid  out  1; register_ready  in  1; register_rs0, register_rs1  out  32 each; register_rs_valid  out  2 -- operand channel.
REQ-015 result_valid  in  1; result_ready  out  1; result_data  in  32 -- result channel.

Function
REQ-016 States IDLE, ISSUE, REGS, RESP, WB; exactly one active; all outputs decoded from registered state/data only, no combinational input-to-output paths.
REQ-017 IDLE: cmd_ready=1; on cmd_valid, capture cmd_instr, cmd_rs0, cmd_rs1 into holding registers, go to ISSUE next cycle.
REQ-018 ISSUE: issue_valid=1, issue_req_instr=held instr, stable until issue_valid&&issue_ready.
REQ-019 ISSUE handshake with issue_resp_accept=1: capture issue_resp_register_read as rr_mask and issue_resp_writeback as wb_en; go to REGS.
REQ-020 ISSUE handshake with issue_resp_accept=0: go to WB with wb_err=1, wb_data=0; no register or result transfer.
REQ-021 REGS: register_valid=1, register_rs0/1=held operands, register_rs_valid=rr_mask; hold until register_valid&&register_ready, then go to RESP with timeout counter cleared to 0.
REQ-022 REGS with rr_mask=2'b00: skip operand transfer, go directly to RESP.
REQ-023 RESP: result_ready=1; on result_valid capture result_data (or 0 when wb_en=0), wb_err=0, go to WB.
REQ-024 RESP without result_valid: counter increments each cycle; when counter==TIMEOUT and result_valid=0, go to WB with wb_err=1, wb_data=0; result_valid in the same cycle as counter==TIMEOUT wins (normal completion).
REQ-025 WB: wb_valid=1, wb_data/wb_err stable until wb_ready; on wb_ready go to IDLE; new cmd accepted no earlier than the cycle after.
REQ-026 Minimum latency, all peers ready: cmd accept cycle N, issue handshake N+1, register handshake N+2, result N+3, wb_valid from N+4.
REQ-027 One outstanding instruction only; cmd_valid outside IDLE ignored (cmd_ready=0).
REQ-028 issue/register/result/wb valid and ready SHALL never assert outside their own state.

Reset
REQ-029 rst low: immediately (asynchronously) state=IDLE; cmd_ready=1; issue_valid, register_valid, result_ready, wb_valid, wb_err=0; wb_data, issue_req_instr, register_rs0/1=0; register_rs_valid=2'b00; counter=0.
REQ-030 Reset mid-transaction SHALL abandon it without completion; first post-reset command behaves as from cold start.

Verification
REQ-031 Add: cmd_instr=0x0000107B? no -- instr 0x0000007B (func3=000), rs0=0x1111, rs1=0x2222; coprocessor accepts, read=2'b11, returns 0x3333 -> wb_valid, wb_data=0x3333, wb_err=0, register_rs_valid=2'b11 seen.
REQ-032 Reject: instr 0x00000033, coprocessor accept=0 -> wb_valid, wb_err=1, wb_data=0, register_valid never 1.
REQ-033 Timeout: TIMEOUT=8, result_valid held 0 -> wb_err=1 exactly 9 cycles after entering RESP; result_valid on cycle 8 instead -> wb_err=0.
REQ-034 Backpressure: issue_ready low 3 cycles, register_ready low 2, wb_ready low 4 -> all held outputs stable throughout, single completion.
REQ-035 Reset in RESP: rst low 1 cycle -> all outputs at REQ-029 values immediately; next command completes normally.
REQ-036 Ignored command: cmd_valid pulsed while in RESP -> cmd_ready=0, no second issue_valid.

Source files
------------

// File: rtl/cvxif_offload_master.sv
// rtl/cvxif_offload_master.sv - CV-X-IF offload master: issue, operands, result wait with timeout, writeback
// One instruction in flight; every output is driven from registered state or registered data.
module cvxif_offload_master #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr,
  input  logic [31:0] cmd_rs0,
  input  logic [31:0] cmd_rs1,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_req_instr,
  input  logic        issue_resp_accept,
  input  logic        issue_resp_writeback,
  input  logic [1:0]  issue_resp_register_read,
  output logic        register_valid,
  input  logic        register_ready,
  output logic [31:0] register_rs0,
  output logic [31:0] register_rs1,
  output logic [1:0]  register_rs_valid,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [31:0] result_data
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_REGS, S_RESP, S_WB} state_t;

  state_t             state, state_d;
  logic [31:0]        instr_q, rs0_q, rs1_q, wb_data_q;
  logic [1:0]         rr_mask;
  logic               wb_en, wb_err_q;
  logic [CNT_W-1:0]   cnt;
  logic               timed_out;

  assign timed_out = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_d = S_ISSUE;
      S_ISSUE: begin
        if (issue_ready) begin
          if (!issue_resp_accept)                   state_d = S_WB;
          else if (issue_resp_register_read == 2'b00) state_d = S_RESP;
          else                                      state_d = S_REGS;
        end
      end
      S_REGS:  if (register_ready) state_d = S_RESP;
      S_RESP:  if (result_valid || timed_out) state_d = S_WB;
      S_WB:    if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter is held at zero outside RESP, so every RESP entry starts a fresh wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q   <= '0;
      rs0_q     <= '0;
      rs1_q     <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
      rr_mask   <= 2'b00;
      wb_en     <= 1'b0;
      cnt       <= '0;
    end else begin
      if (state != S_RESP) cnt <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            instr_q <= cmd_instr;
            rs0_q   <= cmd_rs0;
            rs1_q   <= cmd_rs1;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            rr_mask <= issue_resp_accept ? issue_resp_register_read : 2'b00;
            wb_en   <= issue_resp_writeback;
            if (!issue_resp_accept) begin
              wb_err_q  <= 1'b1;
              wb_data_q <= '0;
            end
          end
        end
        S_RESP: begin
          if (result_valid) begin
            wb_data_q <= wb_en ? result_data : 32'h0;
            wb_err_q  <= 1'b0;
          end else if (timed_out) begin
            wb_data_q <= '0;
            wb_err_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready         = (state == S_IDLE);
  assign issue_valid       = (state == S_ISSUE);
  assign register_valid    = (state == S_REGS);
  assign result_ready      = (state == S_RESP);
  assign wb_valid          = (state == S_WB);
  assign wb_data           = wb_data_q;
  assign wb_err            = wb_err_q;
  assign issue_req_instr   = instr_q;
  assign register_rs0      = rs0_q;
  assign register_rs1      = rs1_q;
  assign register_rs_valid = rr_mask;

endmodule

// File: tb/tb_cvxif_offload_master.sv
// tb/tb_cvxif_offload_master.sv - directed self-checking bench for cvxif_offload_master
module tb_cvxif_offload_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_instr, cmd_rs0, cmd_rs1;
  logic        wb_valid, wb_ready, wb_err;
  logic [31:0] wb_data;
  logic        issue_valid, issue_ready, issue_resp_accept, issue_resp_writeback;
  logic [31:0] issue_req_instr;
  logic [1:0]  issue_resp_register_read;
  logic        register_valid, register_ready;
  logic [31:0] register_rs0, register_rs1;
  logic [1:0]  register_rs_valid;
  logic        result_valid, result_ready;
  logic [31:0] result_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_issue = 0;
  int n_wb    = 0;

  always #5 clk = ~clk;

  cvxif_offload_master #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .cmd_rs0(cmd_rs0), .cmd_rs1(cmd_rs1),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_err(wb_err),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_instr(issue_req_instr),
    .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
    .issue_resp_register_read(issue_resp_register_read),
    .register_valid(register_valid), .register_ready(register_ready),
    .register_rs0(register_rs0), .register_rs1(register_rs1),
    .register_rs_valid(register_rs_valid),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
  );

  always @(posedge clk) begin
    if (issue_valid && issue_ready) n_issue <= n_issue + 1;
    if (wb_valid && wb_ready)       n_wb    <= n_wb + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_instr = instr;
    cmd_rs0   = a;
    cmd_rs1   = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wb(output logic reg_seen);
    int n = 0;
    reg_seen = register_valid;
    while (!wb_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (register_valid) reg_seen = 1'b1;
    end
    check("wb_valid_reached", wb_valid, 1'b1);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!result_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_reached", result_ready, 1'b1);
  endtask

  task automatic finish_wb();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen;
    int   k, base_issue, base_wb;

    rst = 1'b0;
    cmd_valid = 0; cmd_instr = 0; cmd_rs0 = 0; cmd_rs1 = 0;
    wb_ready = 0; issue_ready = 1; issue_resp_accept = 1; issue_resp_writeback = 1;
    issue_resp_register_read = 2'b11; register_ready = 1;
    result_valid = 1; result_data = 32'h3333;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_register_valid", register_valid, 0);
    check("rst_result_ready", result_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_rs_valid", register_rs_valid, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Add with all peers ready: cycle-exact latency
    send_cmd(32'h0000007B, 32'h1111, 32'h2222);
    check("add_issue_valid", issue_valid, 1);
    check("add_issue_instr", issue_req_instr, 32'h7B);
    check("add_cmd_ready_busy", cmd_ready, 0);
    @(negedge clk);
    check("add_register_valid", register_valid, 1);
    check("add_rs_valid", register_rs_valid, 2'b11);
    check("add_rs0", register_rs0, 32'h1111);
    check("add_rs1", register_rs1, 32'h2222);
    @(negedge clk);
    check("add_result_ready", result_ready, 1);
    @(negedge clk);
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_data", wb_data, 32'h3333);
    check("add_wb_err", wb_err, 0);
    finish_wb();
    check("add_back_idle", cmd_ready, 1);
    check("add_wb_dropped", wb_valid, 0);

    // Rejected instruction
    issue_resp_accept = 0;
    send_cmd(32'h00000033, 32'h5, 32'h6);
    wait_wb(seen);
    check("rej_wb_err", wb_err, 1);
    check("rej_wb_data", wb_data, 0);
    check("rej_no_regs", seen, 0);
    finish_wb();
    issue_resp_accept = 1;

    // Timeout with an ignored command pulsed during RESP
    result_valid = 0;
    base_issue = n_issue;
    send_cmd(32'h0000107B, 32'h1, 32'h2);
    wait_resp();
    k = 0;
    while (!wb_valid && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 3) begin
        check("ign_cmd_ready", cmd_ready, 0);
        cmd_valid = 1; cmd_instr = 32'h55;
      end
      if (k == 4) cmd_valid = 0;
    end
    check("to_cycles", k, 9);
    check("to_wb_err", wb_err, 1);
    check("to_wb_data", wb_data, 0);
    finish_wb();
    @(negedge clk);
    check("ign_single_issue", n_issue - base_issue, 1);
    check("ign_no_reissue", issue_valid, 0);

    // Result arriving exactly when the counter reaches TIMEOUT wins
    result_data = 32'hABCD;
    send_cmd(32'h0000207B, 32'h3, 32'h4);
    wait_resp();
    repeat (8) @(negedge clk);
    check("edge_still_resp", result_ready, 1);
    result_valid = 1;
    @(negedge clk);
    result_valid = 0;
    check("edge_wb_valid", wb_valid, 1);
    check("edge_wb_err", wb_err, 0);
    check("edge_wb_data", wb_data, 32'hABCD);
    finish_wb();

    // No writeback and no operand read: data forced to 0, REGS skipped
    issue_resp_writeback = 0; issue_resp_register_read = 2'b00;
    result_valid = 1; result_data = 32'h9999;
    send_cmd(32'h0000307B, 32'h7, 32'h8);
    wait_wb(seen);
    check("nowb_data", wb_data, 0);
    check("nowb_err", wb_err, 0);
    check("nowb_no_regs", seen, 0);
    finish_wb();
    issue_resp_writeback = 1; issue_resp_register_read = 2'b11;

    // Backpressure on issue, register and writeback channels
    issue_ready = 0; register_ready = 0; result_data = 32'h7777;
    base_wb = n_wb;
    send_cmd(32'h0000407B, 32'hAAAA, 32'hBBBB);
    for (int i = 0; i < 3; i++) begin
      check("bp_issue_valid", issue_valid, 1);
      check("bp_issue_instr", issue_req_instr, 32'h407B);
      if (i == 2) issue_ready = 1;
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check("bp_reg_valid", register_valid, 1);
      check("bp_reg_rs0", register_rs0, 32'hAAAA);
      check("bp_reg_rs1", register_rs1, 32'hBBBB);
      if (i == 1) register_ready = 1;
      @(negedge clk);
    end
    check("bp_resp", result_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bp_wb_valid", wb_valid, 1);
      check("bp_wb_data", wb_data, 32'h7777);
      check("bp_wb_err", wb_err, 0);
      @(negedge clk);
    end
    finish_wb();
    repeat (3) @(negedge clk);
    check("bp_single_completion", n_wb - base_wb, 1);

    // Reset while waiting in RESP
    result_valid = 0;
    send_cmd(32'h0000507B, 32'hC, 32'hD);
    wait_resp();
    #2 rst = 1'b0;
    #1;
    check("mrst_cmd_ready", cmd_ready, 1);
    check("mrst_result_ready", result_ready, 0);
    check("mrst_wb_valid", wb_valid, 0);
    check("mrst_issue_instr", issue_req_instr, 0);
    check("mrst_rs0", register_rs0, 0);
    check("mrst_rs_valid", register_rs_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    result_valid = 1; result_data = 32'h4444;
    @(negedge clk);
    send_cmd(32'h0000007B, 32'h1, 32'h2);
    wait_wb(seen);
    check("post_rst_data", wb_data, 32'h4444);
    check("post_rst_err", wb_err, 0);
    finish_wb();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
